lab7_quad_loader: RTL and testbench

- Upstream feeder for the four-input min/max stage.
- Collects four W-bit samples serially from a shared data input (switches), one sample per load event.
- When the fourth sample is captured, commits all four to registered outputs a, b, c, d in a single cycle and pulses frame_valid.
- Outputs hold between frames, so the downstream min/max stage always sees a coherent set of four.

---
 rtl/lab7_quad_loader.sv | 110 +++++++++++
 tb/tb_lab7_quad_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab7_quad_loader.sv
`default_nettype none
// ============================================================================
// Module      : lab7_quad_loader
// Description : Serial four-sample collector feeding the min/max stage.
//               Captures din into three shadow slots. On the fourth capture
//               it commits all four samples to a/b/c/d in one edge, so the
//               downstream stage only ever sees a complete set.
// Revision    : 1.0  initial release
// ============================================================================
module lab7_quad_loader #(
    parameter int W           = 2,
    parameter int EDGE_DETECT = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             load,
    input  logic             clear,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    output logic [W-1:0]     d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic [CNT_W-1:0] frame_cnt
);

    // The fill state is the index of the next slot to be written
    typedef enum logic [1:0] {
        S_SLOT0 = 2'd0,
        S_SLOT1 = 2'd1,
        S_SLOT2 = 2'd2,
        S_SLOT3 = 2'd3
    } slot_t;

    slot_t        r_state;
    logic [W-1:0] r_sh0;
    logic [W-1:0] r_sh1;
    logic [W-1:0] r_sh2;
    logic         w_cap;

    generate
        if (EDGE_DETECT != 0) begin : g_edge
            logic r_load_q;

            // Remember last load level; tracked even during clear so a held
            // button cannot re-trigger once clear drops
            always_ff @(posedge clk) begin
                if (rst) r_load_q <= 1'b0;
                else     r_load_q <= load;
            end

            assign w_cap = load & ~r_load_q;
        end else begin : g_strobe
            assign w_cap = load;
        end
    endgenerate

    // Fill sequencer: shadows take slots 0..2, slot 3 commits the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SLOT0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (clear) begin
                // Abort the partial frame; stale shadows get overwritten later
                r_state <= S_SLOT0;
            end else if (w_cap) begin
                case (r_state)
                    S_SLOT0: begin
                        r_sh0   <= din;
                        r_state <= S_SLOT1;
                    end
                    S_SLOT1: begin
                        r_sh1   <= din;
                        r_state <= S_SLOT2;
                    end
                    S_SLOT2: begin
                        r_sh2   <= din;
                        r_state <= S_SLOT3;
                    end
                    S_SLOT3: begin
                        a           <= r_sh0;
                        b           <= r_sh1;
                        c           <= r_sh2;
                        d           <= din;
                        frame_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + CNT_W'(1);
                        r_state     <= S_SLOT0;
                    end
                    default: r_state <= S_SLOT0;
                endcase
            end
        end
    end

    assign slot = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lab7_quad_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab7_quad_loader
// Description : Scoreboard bench. One instance in button (edge) mode, one in
//               strobe mode. Stimulus pushes expected frames; monitors pop
//               and compare whenever frame_valid is seen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lab7_quad_loader;

    localparam int W     = 2;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [W-1:0]     c;
        logic [W-1:0]     d;
        logic [CNT_W-1:0] cnt;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-mode instance signals
    logic             rst_e, load_e, clear_e;
    logic [W-1:0]     din_e;
    logic [W-1:0]     a_e, b_e, c_e, d_e;
    logic             fv_e;
    logic [1:0]       slot_e;
    logic [CNT_W-1:0] cnt_e;

    // Strobe-mode instance signals
    logic             rst_s, load_s, clear_s;
    logic [W-1:0]     din_s;
    logic [W-1:0]     a_s, b_s, c_s, d_s;
    logic             fv_s;
    logic [1:0]       slot_s;
    logic [CNT_W-1:0] cnt_s;

    lab7_quad_loader #(.W(W), .EDGE_DETECT(1), .CNT_W(CNT_W)) u_edge (
        .clk(clk), .rst(rst_e), .din(din_e), .load(load_e), .clear(clear_e),
        .a(a_e), .b(b_e), .c(c_e), .d(d_e),
        .frame_valid(fv_e), .slot(slot_e), .frame_cnt(cnt_e)
    );

    lab7_quad_loader #(.W(W), .EDGE_DETECT(0), .CNT_W(CNT_W)) u_strobe (
        .clk(clk), .rst(rst_s), .din(din_s), .load(load_s), .clear(clear_s),
        .a(a_s), .b(b_s), .c(c_s), .d(d_s),
        .frame_valid(fv_s), .slot(slot_s), .frame_cnt(cnt_s)
    );

    int n_total = 0;
    int n_pass  = 0;

    frame_t q_e[$];
    frame_t q_s[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic frame_t mk(input int fa, input int fb, input int fc, input int fd, input int fc_cnt);
        frame_t f;
        f.a   = W'(fa);
        f.b   = W'(fb);
        f.c   = W'(fc);
        f.d   = W'(fd);
        f.cnt = CNT_W'(fc_cnt);
        return f;
    endfunction

    // Monitor: every frame_valid cycle must match the oldest expected frame
    always @(negedge clk) begin
        if (fv_e === 1'b1) begin
            if (q_e.size() == 0) chk("edge_unexpected_frame", {a_e, b_e, c_e, d_e, cnt_e}, 32'hFFFF);
            else chk("edge_frame", {a_e, b_e, c_e, d_e, cnt_e}, q_e.pop_front());
        end
        if (fv_s === 1'b1) begin
            if (q_s.size() == 0) chk("strobe_unexpected_frame", {a_s, b_s, c_s, d_s, cnt_s}, 32'hFFFF);
            else chk("strobe_frame", {a_s, b_s, c_s, d_s, cnt_s}, q_s.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button press: high 3 cycles, low 2 cycles
    task automatic press_e(input int v);
        din_e  = W'(v);
        load_e = 1'b1;
        repeat (3) tick();
        load_e = 1'b0;
        repeat (2) tick();
    endtask

    task automatic chk_outs_e(input string name, input logic [7:0] exp);
        chk(name, {a_e, b_e, c_e, d_e}, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_e = 1'b1; load_e = 1'b1; clear_e = 1'b0; din_e = 2'd3;
        rst_s = 1'b1; load_s = 1'b1; clear_s = 1'b0; din_s = 2'd3;

        // ---------------- reset values ----------------
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_outs_e("e_reset_abcd", 8'h00);
            chk("e_reset_slot", slot_e, 0);
            chk("e_reset_cnt", cnt_e, 0);
            chk("e_reset_fv", fv_e, 0);
            chk("s_reset_abcd", {a_s, b_s, c_s, d_s}, 0);
            chk("s_reset_slot", slot_s, 0);
        end
        rst_e = 1'b0; load_e = 1'b0;
        rst_s = 1'b0; load_s = 1'b0;
        tick();

        // ---------------- basic fill, edge mode ----------------
        q_e.push_back(mk(2, 0, 3, 1, 1));
        press_e(2); chk("e_fill_slot1", slot_e, 1); chk_outs_e("e_fill_hold1", 8'h00);
        press_e(0); chk("e_fill_slot2", slot_e, 2); chk_outs_e("e_fill_hold2", 8'h00);
        press_e(3); chk("e_fill_slot3", slot_e, 3); chk_outs_e("e_fill_hold3", 8'h00);
        press_e(1); chk("e_fill_slot0", slot_e, 0);
        chk_outs_e("e_fill_commit", {2'd2, 2'd0, 2'd3, 2'd1});
        chk("e_fill_cnt", cnt_e, 1);

        // ---------------- held button ----------------
        din_e = 2'd2; load_e = 1'b1;
        repeat (10) tick();
        load_e = 1'b0;
        tick();
        chk("e_held_slot", slot_e, 1);

        // ---------------- clear mid-frame ----------------
        clear_e = 1'b1; tick(); clear_e = 1'b0;
        chk("e_clear1_slot", slot_e, 0);
        press_e(3); press_e(3);
        chk("e_clear_pre_slot", slot_e, 2);
        din_e = 2'd0; load_e = 1'b1; clear_e = 1'b1;
        tick();
        clear_e = 1'b0;
        chk("e_clear_slot", slot_e, 0);
        repeat (2) tick();
        chk("e_clear_no_cap", slot_e, 0);
        load_e = 1'b0;
        tick();
        chk_outs_e("e_clear_abcd", {2'd2, 2'd0, 2'd3, 2'd1});
        chk("e_clear_cnt", cnt_e, 1);
        q_e.push_back(mk(1, 1, 1, 1, 2));
        repeat (4) press_e(1);
        chk_outs_e("e_after_clear_abcd", 8'h55);

        // ---------------- reset mid-fill ----------------
        press_e(2); press_e(1);
        chk("e_midfill_slot", slot_e, 2);
        rst_e = 1'b1; tick(); rst_e = 1'b0;
        chk("e_midrst_slot", slot_e, 0);
        chk_outs_e("e_midrst_abcd", 8'h00);
        chk("e_midrst_cnt", cnt_e, 0);

        // ---------------- strobe mode ----------------
        begin
            int vals[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
            q_s.push_back(mk(0, 1, 2, 3, 1));
            q_s.push_back(mk(3, 2, 1, 0, 2));
            load_s = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                din_s = W'(vals[k-1]);
                tick();
                chk("s_fv_timing", fv_s, (k == 4 || k == 8) ? 1 : 0);
            end
            load_s = 1'b0;
            tick();
            chk("s_fv_low", fv_s, 0);
            chk("s_cnt2", cnt_s, 2);
            chk("s_abcd2", {a_s, b_s, c_s, d_s}, {2'd3, 2'd2, 2'd1, 2'd0});
        end

        // ---------------- frame counter wrap ----------------
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        chk("s_wrap_rst_cnt", cnt_s, 0);
        load_s = 1'b1;
        for (int f = 0; f < 16; f++) begin
            q_s.push_back(mk(f & 3, (f + 1) & 3, (f + 2) & 3, (f + 3) & 3, (f + 1) & 15));
            for (int j = 0; j < 4; j++) begin
                din_s = W'((f + j) & 3);
                tick();
            end
        end
        load_s = 1'b0;
        tick();
        chk("s_wrap_cnt", cnt_s, 0);
        chk("s_wrap_slot", slot_s, 0);

        // Two captures then reset: partial frame discarded, outputs zeroed
        load_s = 1'b1; din_s = 2'd3;
        repeat (2) tick();
        load_s = 1'b0;
        chk("s_midfill_slot", slot_s, 2);
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        chk("s_midrst_slot", slot_s, 0);
        chk("s_midrst_abcd", {a_s, b_s, c_s, d_s}, 0);

        repeat (2) tick();
        chk("e_pending_frames", q_e.size(), 0);
        chk("s_pending_frames", q_s.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
